aim_noc_ni_tx: RTL

Network-interface transmitter on the core side of the AIM mesh router's local port. Accepts packet requests (destination and length) and a payload word stream from the compute core. Frames them into 64-bit flits (HEAD, BODY, TAIL) and injects one flit per cycle into the router's local_in. It is the injecting end of the local port and honours a stall from the router.

---
 rtl/aim_noc_pkg.sv | 32 +++
 rtl/aim_noc_sync_fifo.sv | 51 +++++
 rtl/aim_noc_ni_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/aim_noc_pkg.sv
// rtl/aim_noc_pkg.sv - flit type encoding, HEAD field layout and NI FSM states
package aim_noc_pkg;

  localparam int FLIT_TYPE_W = 2;

  localparam logic [FLIT_TYPE_W-1:0] FLIT_IDLE = 2'b00;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD = 2'b01;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY = 2'b10;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL = 2'b11;

  localparam int HEAD_DST_X     = 0;
  localparam int HEAD_DST_Y     = 1;
  localparam int HEAD_SRC_X     = 2;
  localparam int HEAD_SRC_Y     = 3;
  localparam int HEAD_N_COORDS  = 4;

  // HEAD coordinates pack downward from just below the type bits; len sits under them.
  function automatic int head_coord_lsb(input int data_w, input int coord_w, input int idx);
    return data_w - FLIT_TYPE_W - (idx + 1) * coord_w;
  endfunction

  function automatic int head_len_lsb(input int data_w, input int coord_w, input int len_w);
    return data_w - FLIT_TYPE_W - HEAD_N_COORDS * coord_w - len_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2
  } ni_state_e;

endpackage

// File: rtl/aim_noc_sync_fifo.sv
// rtl/aim_noc_sync_fifo.sv - first-word-fall-through synchronous FIFO with full/empty
module aim_noc_sync_fifo #(
  parameter int WIDTH = 62,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/aim_noc_ni_tx.sv
// rtl/aim_noc_ni_tx.sv - NI transmitter: frames requests and payload into HEAD/BODY/TAIL flits
module aim_noc_ni_tx
  import aim_noc_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int COORD_W    = 4,
  parameter int LEN_W      = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COORD_W-1:0]       cfg_src_x,
  input  logic [COORD_W-1:0]       cfg_src_y,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [COORD_W-1:0]       req_dst_x,
  input  logic [COORD_W-1:0]       req_dst_y,
  input  logic [LEN_W-1:0]         req_len,
  input  logic                     pld_valid,
  output logic                     pld_ready,
  input  logic [DATA_W-3:0]        pld_data,
  input  logic                     noc_stall,
  output logic [DATA_W-1:0]        flit_out,
  output logic                     pkt_sent,
  output logic                     busy
);

  localparam int PLD_W     = DATA_W - FLIT_TYPE_W;
  localparam int DST_X_LSB = head_coord_lsb(DATA_W, COORD_W, HEAD_DST_X);
  localparam int DST_Y_LSB = head_coord_lsb(DATA_W, COORD_W, HEAD_DST_Y);
  localparam int SRC_X_LSB = head_coord_lsb(DATA_W, COORD_W, HEAD_SRC_X);
  localparam int SRC_Y_LSB = head_coord_lsb(DATA_W, COORD_W, HEAD_SRC_Y);
  localparam int LEN_LSB   = head_len_lsb(DATA_W, COORD_W, LEN_W);

  ni_state_e          state_q, state_d;
  logic [COORD_W-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [COORD_W-1:0] src_x_q, src_x_d, src_y_q, src_y_d;
  logic [LEN_W-1:0]   len_q, len_d, rem_q, rem_d;
  logic [DATA_W-1:0]  flit_q, flit_d, head_flit;
  logic               sent_q, sent_d;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PLD_W-1:0]   fifo_rdata;

  assign pld_ready = !fifo_full;
  assign fifo_push = pld_valid && pld_ready;

  aim_noc_sync_fifo #(
    .WIDTH (PLD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pld_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (pld_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    head_flit                              = '0;
    head_flit[DATA_W-1 -: FLIT_TYPE_W]     = FLIT_HEAD;
    head_flit[DST_X_LSB +: COORD_W]        = dst_x_q;
    head_flit[DST_Y_LSB +: COORD_W]        = dst_y_q;
    head_flit[SRC_X_LSB +: COORD_W]        = src_x_q;
    head_flit[SRC_Y_LSB +: COORD_W]        = src_y_q;
    head_flit[LEN_LSB +: LEN_W]            = len_q;
  end

  always_comb begin
    state_d   = state_q;
    dst_x_d   = dst_x_q;
    dst_y_d   = dst_y_q;
    src_x_d   = src_x_q;
    src_y_d   = src_y_q;
    len_d     = len_q;
    rem_d     = rem_q;
    flit_d    = '0;
    sent_d    = 1'b0;
    req_ready = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          dst_x_d = req_dst_x;
          dst_y_d = req_dst_y;
          src_x_d = cfg_src_x;
          src_y_d = cfg_src_y;
          len_d   = req_len;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (!noc_stall) begin
          flit_d = head_flit;
          if (len_q == '0) begin
            sent_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rem_d   = len_q;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // A stall or an empty FIFO emits a bubble and leaves remaining untouched.
        if (!noc_stall && !fifo_empty) begin
          fifo_pop = 1'b1;
          rem_d    = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            flit_d  = {FLIT_TAIL, fifo_rdata};
            sent_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            flit_d  = {FLIT_BODY, fifo_rdata};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dst_x_q <= '0;
      dst_y_q <= '0;
      src_x_q <= '0;
      src_y_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      flit_q  <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      flit_q  <= flit_d;
      sent_q  <= sent_d;
    end
  end

  assign flit_out = flit_q;
  assign pkt_sent = sent_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule
